month_year_counter: RTL and testbench

//   Calendar stage above the day counter: consumes the day counter's end-of-month carry.

---
 rtl/millennium_clock_pkg.sv | 32 +++
 rtl/bcd_digit_counter.sv | 41 ++++
 rtl/month_year_counter.sv | 121 ++++++++++++
 tb/tb_month_year_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/millennium_clock_pkg.sv
// rtl/millennium_clock_pkg.sv - shared calendar constants and BCD leap-year helper
//
// Purpose : constants and helper functions shared by the month/year counter and
//           by the display/alarm logic that also needs the leap-year rule.
// Contents: MONTH_JAN, MONTH_DEC, BCD_MAX, YEAR_W, bcd_div4(), is_leap_bcd().
package millennium_clock_pkg;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_DEC = 4'd12;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         YEAR_W    = 16;

  // Two-digit BCD number "ab" divisible by 4: an even tens digit needs ones in
  // {0,4,8}; an odd tens digit needs ones in {2,6}.
  function automatic logic bcd_div4(input logic [3:0] a, input logic [3:0] b);
    logic w_b_048;
    logic w_b_26;
    w_b_048 = (b == 4'd0) || (b == 4'd4) || (b == 4'd8);
    w_b_26  = (b == 4'd2) || (b == 4'd6);
    return (!a[0] && w_b_048) || (a[0] && w_b_26);
  endfunction

  // Gregorian leap rule on a 4-digit BCD year: century years test the
  // thousands/hundreds pair, all other years test the tens/ones pair.
  function automatic logic is_leap_bcd(input logic [YEAR_W-1:0] year_bcd);
    if (year_bcd[7:0] == 8'h00)
      return bcd_div4(year_bcd[15:12], year_bcd[11:8]);
    else
      return bcd_div4(year_bcd[7:4], year_bcd[3:0]);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit up/down counter for a ripple chain
//
// Purpose : one decimal digit 0..9 that steps up or down and flags wrap.
// Ports   : clk      in  1  system clock
//           rst      in  1  synchronous active-high reset
//           rst_val  in  4  digit value loaded on reset
//           up       in  1  step up this cycle (wins over down)
//           down     in  1  step down this cycle
//           digit    out 4  current digit, always 0..9
//           carry    out 1  up requested while digit is 9 (wraps to 0)
//           borrow   out 1  down requested while digit is 0 (wraps to 9)
module bcd_digit_counter
  import millennium_clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rst_val,
  input  logic       up,
  input  logic       down,
  output logic [3:0] digit,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] r_digit;

  assign digit  = r_digit;
  assign carry  = up && (r_digit == BCD_MAX);
  assign borrow = down && !up && (r_digit == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= rst_val;
    end else if (up) begin
      r_digit <= carry ? 4'd0 : r_digit + 4'd1;
    end else if (down) begin
      r_digit <= borrow ? BCD_MAX : r_digit - 4'd1;
    end
  end

endmodule

// File: rtl/month_year_counter.sv
// rtl/month_year_counter.sv - month register and 4-digit BCD year above the day counter
//
// Purpose : advances month/year on the day counter's end-of-month carry, allows
//           manual month/year adjustment in set mode, reports leap year and the
//           year 9999 -> 0000 rollover carry.
// Config  : define MILLENNIUM_PULSE_EN to add the registered millennium_pulse output.
// Ports   : clk              in  1   system clock
//           rst              in  1   synchronous active-high reset
//           carry_in_day     in  1   day counter wrapped past the last day of month
//           ctrl_set         in  1   set mode; inc/dec adjust the selected field
//           sel_year         in  1   0 = adjust month, 1 = adjust year
//           inc              in  1   increment selected field
//           dec              in  1   decrement selected field (inc wins)
//           current_month    out 4   month 1..12
//           year_bcd         out 16  year, BCD thousands..ones
//           is_leap_year     out 1   leap flag of the current year
//           carry_out        out 1   Dec 9999 rolling over this cycle
//           millennium_pulse out 1   (MILLENNIUM_PULSE_EN) one cycle after a carry to x000
module month_year_counter
  import millennium_clock_pkg::*;
#(
  parameter logic [3:0]        RESET_MONTH = 4'd1,
  parameter logic [YEAR_W-1:0] RESET_YEAR  = 16'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carry_in_day,
  input  logic              ctrl_set,
  input  logic              sel_year,
  input  logic              inc,
  input  logic              dec,
  output logic [3:0]        current_month,
  output logic [YEAR_W-1:0] year_bcd,
  output logic              is_leap_year,
`ifdef MILLENNIUM_PULSE_EN
  output logic              millennium_pulse,
`endif
  output logic              carry_out
);

  logic [3:0]        r_month;
  logic [3:0]        w_month_next;
  logic [YEAR_W-1:0] w_year;

  logic w_norm_step;
  logic w_month_is_dec;
  logic w_set_inc;
  logic w_set_dec;
  logic w_year_up;
  logic w_year_down;

  // Index 0 feeds the ones digit; index i+1 is the carry/borrow out of digit i.
  logic [4:0] w_up;
  logic [4:0] w_down;

  // Set mode masks the day carry entirely; inc has priority over dec.
  assign w_norm_step    = carry_in_day && !ctrl_set;
  assign w_month_is_dec = (r_month == MONTH_DEC);
  assign w_set_inc      = ctrl_set && inc;
  assign w_set_dec      = ctrl_set && dec && !inc;

  assign w_year_up   = (w_norm_step && w_month_is_dec) || (w_set_inc && sel_year);
  assign w_year_down = w_set_dec && sel_year;

  always_comb begin
    w_month_next = r_month;
    if (w_norm_step || (w_set_inc && !sel_year)) begin
      w_month_next = w_month_is_dec ? MONTH_JAN : r_month + 4'd1;
    end else if (w_set_dec && !sel_year) begin
      w_month_next = (r_month == MONTH_JAN) ? MONTH_DEC : r_month - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_month <= RESET_MONTH;
    end else begin
      r_month <= w_month_next;
    end
  end

  assign w_up[0]   = w_year_up;
  assign w_down[0] = w_year_down;

  for (genvar gi = 0; gi < 4; gi++) begin : g_year_digit
    bcd_digit_counter u_digit (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_YEAR[4*gi +: 4]),
      .up      (w_up[gi]),
      .down    (w_down[gi]),
      .digit   (w_year[4*gi +: 4]),
      .carry   (w_up[gi+1]),
      .borrow  (w_down[gi+1])
    );
  end

  assign current_month = r_month;
  assign year_bcd      = w_year;
  assign is_leap_year  = is_leap_bcd(w_year);

  // Carry out of the thousands digit only happens at 9999; masking with set mode
  // keeps manual year edits from looking like a calendar rollover.
  assign carry_out = w_up[4] && !ctrl_set;

`ifdef MILLENNIUM_PULSE_EN
  logic r_millennium_pulse;

  // The year lands on x000 exactly when a calendar carry increments an x999 year.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_millennium_pulse <= 1'b0;
    end else begin
      r_millennium_pulse <= w_norm_step && w_month_is_dec && (w_year[11:0] == 12'h999);
    end
  end

  assign millennium_pulse = r_millennium_pulse;
`endif

endmodule

// File: tb/tb_month_year_counter.sv
// tb/tb_month_year_counter.sv - directed and random check of month_year_counter
module tb_month_year_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        carry_in_day = 1'b0;
  logic        ctrl_set = 1'b0;
  logic        sel_year = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic [3:0]  current_month;
  logic [15:0] year_bcd;
  logic        is_leap_year;
  logic        carry_out;
`ifdef MILLENNIUM_PULSE_EN
  logic        millennium_pulse;
`endif

  month_year_counter dut (
    .clk           (clk),
    .rst           (rst),
    .carry_in_day  (carry_in_day),
    .ctrl_set      (ctrl_set),
    .sel_year      (sel_year),
    .inc           (inc),
    .dec           (dec),
    .current_month (current_month),
    .year_bcd      (year_bcd),
    .is_leap_year  (is_leap_year),
`ifdef MILLENNIUM_PULSE_EN
    .millennium_pulse (millennium_pulse),
`endif
    .carry_out     (carry_out)
  );

  always #5 clk = ~clk;

  // Reference model: month as 1..12, year as a plain decimal integer.
  int m_month = 1;
  int m_year  = 2000;
  int m_pulse = 0;

  function automatic logic [15:0] to_bcd(input int y);
    return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
  endfunction

  function automatic int leap_of(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_pulse <= 0;
    if (rst) begin
      m_month <= 1;
      m_year  <= 2000;
    end else if (ctrl_set) begin
      if (inc) begin
        if (!sel_year) m_month <= (m_month == 12) ? 1 : m_month + 1;
        else           m_year  <= (m_year + 1) % 10000;
      end else if (dec) begin
        if (!sel_year) m_month <= (m_month == 1) ? 12 : m_month - 1;
        else           m_year  <= (m_year + 9999) % 10000;
      end
    end else if (carry_in_day) begin
      if (m_month == 12) begin
        m_month <= 1;
        m_year  <= (m_year + 1) % 10000;
        m_pulse <= ((m_year + 1) % 1000 == 0) ? 1 : 0;
      end else begin
        m_month <= m_month + 1;
      end
    end
  end

  // Literal expectations posted by the stimulus process, consumed at the next negedge.
  int          lit_req = 0;
  string       lit_name = "";
  int          lit_m = 0;
  logic [15:0] lit_y = '0;
  int          lit_l = 0;
  int          lit_c = 0;
  bit          cmp_on = 1'b0;

  int total = 0;
  int bad   = 0;
  int lit_seen = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("month", int'(current_month), m_month);
      chk("year", int'(year_bcd), int'(to_bcd(m_year)));
      chk("leap", int'(is_leap_year), leap_of(m_year));
      chk("carry_out", int'(carry_out),
          (carry_in_day && !ctrl_set && m_month == 12 && m_year == 9999) ? 1 : 0);
`ifdef MILLENNIUM_PULSE_EN
      chk("millennium_pulse", int'(millennium_pulse), m_pulse);
`endif
      for (int d = 0; d < 4; d++) begin
        total++;
        if (year_bcd[4*d +: 4] > 4'd9) begin
          bad++;
          $display("FAIL bcd_digit%0d got=%0h want=<=9", d, year_bcd[4*d +: 4]);
        end
      end
      if (lit_seen != lit_req) begin
        lit_seen = lit_req;
        chk({lit_name, "_month"}, int'(current_month), lit_m);
        chk({lit_name, "_year"}, int'(year_bcd), int'(lit_y));
        chk({lit_name, "_leap"}, int'(is_leap_year), lit_l);
        chk({lit_name, "_carry"}, int'(carry_out), lit_c);
        chk({lit_name, "_model_month"}, m_month, lit_m);
        chk({lit_name, "_model_year"}, int'(to_bcd(m_year)), int'(lit_y));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit r, input bit c, input bit s, input bit y, input bit i, input bit d);
    rst = r; carry_in_day = c; ctrl_set = s; sel_year = y; inc = i; dec = d;
  endtask

  task automatic post(input string nm, input int mo, input logic [15:0] yr, input int lp, input int co);
    lit_name = nm; lit_m = mo; lit_y = yr; lit_l = lp; lit_c = co;
    lit_req++;
  endtask

  task automatic set_month(input int target);
    for (int n = 0; n < 12 && m_month != target; n++) begin
      drv(0, 0, 1, 0, 1, 0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_year(input int target);
    int up_dist;
    up_dist = (target - m_year + 10000) % 10000;
    if (up_dist <= 5000) begin
      for (int n = 0; n < up_dist; n++) begin drv(0, 0, 1, 1, 1, 0); tick(); end
    end else begin
      for (int n = 0; n < 10000 - up_dist; n++) begin drv(0, 0, 1, 1, 0, 1); tick(); end
    end
    drv(0, 0, 0, 0, 0, 0);
  endtask

  int years[5]    = '{1900, 2024, 2100, 2400, 2023};
  int leap_exp[5] = '{0, 1, 0, 1, 0};

  initial begin
    drv(1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    cmp_on = 1'b1;
    post("reset", 1, 16'h2000, 1, 0);
    tick();

    set_month(12);
    set_year(1999);
    post("preload_1999", 12, 16'h1999, 0, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("rollover_2000", 1, 16'h2000, 1, 0);
    tick();

    for (int k = 0; k < 5; k++) begin
      set_month(2);
      set_year(years[k]);
      post($sformatf("leap_%0d", years[k]), 2, to_bcd(years[k]), leap_exp[k], 0);
      tick();
    end

    set_month(1);
    drv(0, 0, 1, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("set_dec_month", 12, 16'h2023, 0, 0);
    drv(0, 0, 1, 0, 1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("set_incdec_month", 1, 16'h2023, 0, 0);
    drv(0, 1, 1, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("set_ignores_carry", 1, 16'h2023, 0, 0);
    tick();

    set_month(12);
    set_year(9999);
    drv(0, 1, 0, 0, 0, 0);
    post("carry_out_9999", 12, 16'h9999, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("wrap_0000", 1, 16'h0000, 1, 0);
    drv(0, 0, 1, 1, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("year_dec_0000", 1, 16'h9999, 0, 0);
    drv(1, 1, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    post("reset_wins", 1, 16'h2000, 1, 0);
    tick();

    for (int n = 0; n < 10000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1999) == 0) begin
        drv(1, $urandom_range(0, 1) == 1, 0, 0, $urandom_range(0, 1) == 1, 0);
      end else if (r < 8) begin
        drv(0, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        drv(0, r < 60, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
